regfile_mp_sb: RTL
==================

// Module: regfile_mp_sb
// PURPOSE
//  Multi-port integer register file with a per-register pending-write scoreboard.
//  Generalises the single-write, dual-read file to NRD read ports and NWR write ports.
//  Adds asynchronous reset initialisation of all registers and a busy bit per register,
//  so issue can stall on RAW hazards. Sits between decode/issue (reads, alloc) and writeback.
// PARAMETERS
//  XLEN    32            data width
//  NREGS   32            number of architectural registers; AW = $clog2(NREGS)
//  NRD     2             read ports
//  NWR     2             write ports; a higher port index has higher priority
//  SP_IDX  2             register preset at reset (stack pointer)
//  SP_INIT 32'h0110_0000 reset value of SP_IDX (memory start + memory depth)
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high
//  rd_addr     in   NRD x AW   read addresses
//  rd_data     out  NRD x XLEN combinational read data
//  rd_busy     out  NRD        register addressed by the port has a pending write
//  wr_en       in   NWR        write strobes
//  wr_addr     in   NWR x AW   write addresses
//  wr_data     in   NWR x XLEN write data
//  alloc_en    in   1          issue marks alloc_addr as pending
//  alloc_addr  in   AW         destination being allocated
//  flush       in   1          clear all busy bits (pipeline flush)
// BEHAVIOUR
//  - Reset (async assert, sync release): all regs 0 except reg[SP_IDX]=SP_INIT; all busy=0.
//  - Reads are combinational, no latency. Address 0 always reads 0 with busy=0.
//  - Writes commit on posedge clk. Writes to reg 0 are ignored and do not affect busy.
//  - Two ports writing the same address in one cycle: the highest-index port's data commits.
//  - A write to r clears busy[r] at the same edge.
//  - alloc_en sets busy[alloc_addr] (ignored for 0). Alloc and write to the same r in one
//    cycle: busy[r] ends 1 (alloc wins); the data still commits.
//  - flush clears every busy bit and overrides a same-cycle alloc. Same-cycle writes commit.
//  - Re-alloc of an already-busy reg keeps it busy; there is no counting.
//  - Out-of-range addresses (>= NREGS, when NREGS is not a power of 2): reads return 0,
//    writes and allocs are ignored.
//  - Reset mid-operation discards all in-flight writes and allocs of that cycle.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a read matching an active same-cycle write address returns
//    that wr_data (highest-index matching port) and reports rd_busy=0 unless alloc_en
//    targets the same reg in that cycle.
//  Undefined: reads return the stored value and stored busy. The written value is visible
//    from the next cycle.
// STRUCTURE
//  Package regfile_pkg: XLEN, NREGS, AW, typedef reg_idx_t [AW-1:0], typedef xword_t
//    [XLEN-1:0], SP_IDX, SP_INIT.
//  Sub-module regfile_busy_table: busy vector, alloc/clear/flush priority, per-port lookup.
//  Storage, write-priority and bypass muxing stay in regfile_mp_sb.
// TESTING
//  1 Reset -> reading r2 gives 0x0110_0000 and r5 gives 0; all rd_busy=0; hold reset and
//    toggle wr_en -> no change.
//  2 wr0 r5=0xDEADBEEF and wr1 r5=0x12345678 in the same cycle -> next cycle r5 reads
//    0x12345678.
//  3 Write r0=0xFFFFFFFF and alloc r0 -> r0 reads 0 with busy 0.
//  4 alloc r7 -> next cycle busy=1; write r7=0xA5 -> next cycle busy=0 and data 0xA5.
//    alloc r7 and write r7 in the same cycle -> busy stays 1.
//  5 alloc r3 and r9 over two cycles, then flush together with alloc r4 -> all busy=0 and
//    r4 not busy.
//  6 Write r6=0x55 while reading r6 in the same cycle -> with REGFILE_BYPASS_EN 0x55 and
//    busy 0; without it the old value that cycle, 0x55 next cycle.
//    Assert reset mid-write -> r6 returns to 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Purpose : shared types and constants for the multi-port register file slice.
// Latency : n/a (types, constants and a pure helper function only).
// Backpr. : n/a.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xword_t;

  // Stack pointer is preset so software can use the stack straight out of reset.
  localparam int     SP_IDX  = 2;
  localparam xword_t SP_INIT = 32'h0110_0000;

  // True for a register that can hold state: never r0, and never an index past
  // the end of the file (only reachable when NREGS is not a power of two).
  function automatic logic idx_ok(input reg_idx_t a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

endpackage

// File: rtl/regfile_busy_table.sv
// Purpose : per-register pending-write (busy) bits with alloc/clear/flush priority.
// Latency : updates on posedge clk; lookups are combinational (stored state only).
// Backpr. : none; the issue stage stalls on rd_busy itself.
// Ports   : clk, reset (async, active-high); wr_en/wr_addr clear bits;
//           alloc_en/alloc_addr set a bit; flush clears all; rd_addr -> rd_busy lookup.
module regfile_busy_table
  import regfile_pkg::*;
#(
  parameter int NRD = 2,
  parameter int NWR = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic     [NWR-1:0]   wr_en,
  input  reg_idx_t [NWR-1:0]   wr_addr,
  input  logic                 alloc_en,
  input  reg_idx_t             alloc_addr,
  input  logic                 flush,
  input  reg_idx_t [NRD-1:0]   rd_addr,
  output logic     [NRD-1:0]   rd_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Priority, lowest to highest: hold, write clears, alloc sets, flush clears all.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && idx_ok(wr_addr[w])) busy_nxt[wr_addr[w]] = 1'b0;
    end
    if (alloc_en && idx_ok(alloc_addr)) busy_nxt[alloc_addr] = 1'b1;
    if (flush) busy_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (idx_ok(rd_addr[p])) rd_busy[p] = busy[rd_addr[p]];
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Purpose : NRD-read / NWR-write integer register file with pending-write scoreboard.
// Latency : reads combinational; writes and busy updates visible after posedge clk.
// Backpr. : none; rd_busy lets issue stall on RAW hazards.
// Ports   : clk, reset (async, active-high); rd_addr -> rd_data/rd_busy;
//           wr_en/wr_addr/wr_data (highest port index wins); alloc_en/alloc_addr; flush.
// Option  : REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int NRD = 2,
  parameter int NWR = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  reg_idx_t [NRD-1:0]   rd_addr,
  output xword_t   [NRD-1:0]   rd_data,
  output logic     [NRD-1:0]   rd_busy,
  input  logic     [NWR-1:0]   wr_en,
  input  reg_idx_t [NWR-1:0]   wr_addr,
  input  xword_t   [NWR-1:0]   wr_data,
  input  logic                 alloc_en,
  input  reg_idx_t             alloc_addr,
  input  logic                 flush
);

  xword_t           regs [NREGS];
  logic [NRD-1:0]   stored_busy;

  regfile_busy_table #(.NRD(NRD), .NWR(NWR)) u_busy (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_busy    (stored_busy)
  );

  // Ports are scanned low to high so the last (highest-index) NBA to an
  // address is the one that lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && idx_ok(wr_addr[w])) regs[wr_addr[w]] <= wr_data[w];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (idx_ok(rd_addr[p])) rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = stored_busy[p];
`ifdef REGFILE_BYPASS_EN
      // A write landing this cycle resolves the hazard, unless the same reg is
      // being re-allocated in the same cycle.
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && idx_ok(wr_addr[w]) && (wr_addr[w] == rd_addr[p])) begin
          rd_data[p] = wr_data[w];
          rd_busy[p] = alloc_en && (alloc_addr == rd_addr[p]);
        end
      end
`endif
    end
  end

endmodule
